// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative data cache.
//   state_e : miss-handling FSM states
//   clog2   : ceiling log2 used to derive address-field widths
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    FILL      = 2'd3
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Bus interfaces of the data cache.
//   dcache_cpu_if : CPU memory-stage port (word access). master = CPU, slave = cache.
//     wdata/addr/MemRead/MemWrite towards the cache, rdata/stall back to the CPU.
//   dcache_mem_if : line-wide memory port. master = cache, slave = memory.
//     wdata/addr/enable/write towards memory, rdata/ack back to the cache.
interface dcache_cpu_if #(
  parameter int ADDR_W = 32
);
  logic [31:0]       wdata;
  logic [ADDR_W-1:0] addr;
  logic              MemRead;
  logic              MemWrite;
  logic [31:0]       rdata;
  logic              stall;

  modport master (output wdata, addr, MemRead, MemWrite, input rdata, stall);
  modport slave  (input wdata, addr, MemRead, MemWrite, output rdata, stall);
endinterface

interface dcache_mem_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 32
);
  logic [LINE_BYTES*8-1:0] wdata;
  logic [ADDR_W-1:0]       addr;
  logic                    enable;
  logic                    write;
  logic [LINE_BYTES*8-1:0] rdata;
  logic                    ack;

  modport master (output wdata, addr, enable, write, input rdata, ack);
  modport slave  (input wdata, addr, enable, write, output rdata, ack);
endinterface

// File: rtl/dcache_repl.sv
// Per-set replacement state of the data cache.
// Default build: round-robin pointer per set, advanced on every refill of the set.
// With DCACHE_PLRU_EN defined: tree pseudo-LRU (WAYS-1 bits per set), updated on
// every hit and refill so the tree points away from the accessed way.
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset (clears all state)
//   upd_i              an access (hit or refill) happened this cycle
//   upd_refill_i       the access is a refill
//   upd_set_i/_way_i   set and way that were accessed
//   rd_set_i           set being looked up for a miss
//   victim_o           way the policy would replace in rd_set_i
module dcache_repl #(
  parameter int SETS  = 32,
  parameter int WAYS  = 2,
  parameter int IDX_W = 5,
  parameter int WAY_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             upd_i,
  input  logic             upd_refill_i,
  input  logic [IDX_W-1:0] upd_set_i,
  input  logic [WAY_W-1:0] upd_way_i,
  input  logic [IDX_W-1:0] rd_set_i,
  output logic [WAY_W-1:0] victim_o
);

  if (WAYS == 1) begin : g_direct
    // Direct-mapped: the only way is always the victim, no state needed.
    logic unused_direct;
    assign unused_direct = ^{clk_i, rst_i, upd_i, upd_refill_i, upd_set_i, upd_way_i, rd_set_i};
    assign victim_o      = '0;
  end else begin : g_policy
`ifdef DCACHE_PLRU_EN
    // Tree nodes use heap numbering 1..WAYS-1; bit value 0 means "left subtree is older".
    logic [WAYS-1:1] plru_q [SETS];
    logic [WAYS-1:0] plru_next_unused;
    logic            unused_refill;

    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-1:0] tree);
      logic [WAY_W:0] node;
      node = (WAY_W+1)'(1);
      for (int l = 0; l < WAY_W; l++) begin
        node = {node[WAY_W-1:0], tree[node[WAY_W-1:0]]};
      end
      return node[WAY_W-1:0];
    endfunction

    function automatic logic [WAYS-1:0] plru_touch(input logic [WAYS-1:0] tree,
                                                   input logic [WAY_W-1:0] way);
      logic [WAYS-1:0] r;
      logic [WAY_W:0]  node;
      logic            b;
      r    = tree;
      node = (WAY_W+1)'(1);
      for (int l = 0; l < WAY_W; l++) begin
        b = way[WAY_W-1-l];
        r[node[WAY_W-1:0]] = ~b;
        node = {node[WAY_W-1:0], b};
      end
      return r;
    endfunction

    assign plru_next_unused = plru_touch({plru_q[upd_set_i], 1'b0}, upd_way_i);
    assign victim_o         = plru_victim({plru_q[rd_set_i], 1'b0});
    assign unused_refill    = upd_refill_i;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
      end else if (upd_i) begin
        plru_q[upd_set_i] <= plru_next_unused[WAYS-1:1];
      end
    end
`else
    logic [WAY_W-1:0] ptr_q [SETS];
    logic             unused_way;

    assign unused_way = ^upd_way_i;
    assign victim_o   = ptr_q[rd_set_i];

    // WAYS is a power of two, so the natural WAY_W-bit wrap is modulo WAYS.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
      end else if (upd_i && upd_refill_i) begin
        ptr_q[upd_set_i] <= ptr_q[upd_set_i] + 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/dcache_assoc_top.sv
// N-way set-associative, write-back, write-allocate L1 data cache.
// Optional feature macro: DCACHE_PLRU_EN selects tree pseudo-LRU victim choice
// instead of the default per-set round-robin pointer.
// Ports:
//   clk_i  clock
//   rst_i  synchronous active-high reset; aborts any miss in flight, drops dirty data
//   p1     CPU word port (slave): combinational hit/stall/read data
//   mem    line memory port (master): registered enable/write/addr/data, ack pulse back
module dcache_assoc_top
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 32,
  parameter int SETS       = 32,
  parameter int WAYS       = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  dcache_cpu_if.slave  p1,
  dcache_mem_if.master mem
);

  localparam int OFF_W  = clog2(LINE_BYTES);
  localparam int IDX_W  = clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WRD_W  = OFF_W - 2;
  localparam int WAY_W  = (WAYS > 1) ? clog2(WAYS) : 1;
  localparam int LINE_W = LINE_BYTES * 8;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WRD_W-1:0]  req_word;
  logic [1:0]        unused_byte;
  logic              req, req_wr;

  assign {req_tag, req_idx, req_word, unused_byte} = p1.addr;
  assign req    = p1.MemRead | p1.MemWrite;
  assign req_wr = p1.MemWrite;   // read+write together behaves as a write

  // Tag/data storage carries no reset; valid/dirty qualify it.
  logic [TAG_W-1:0]  tag_q  [WAYS][SETS];
  logic [LINE_W-1:0] line_q [WAYS][SETS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];

  state_e            state_q;
  logic              mem_en_q, mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_line_q;
  logic [WAY_W-1:0]  vic_way_q;
  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  fill_tag_q;

  logic [WAYS-1:0]   way_match;
  logic [WAY_W-1:0]  hit_way, free_way, repl_victim, victim_way_d;
  logic              any_free, hit, miss, vic_dirty;
  logic [LINE_W-1:0] hit_line;

  // Lowest-numbered match / invalid way wins (loop runs high to low).
  always_comb begin
    way_match = '0;
    hit_way   = '0;
    free_way  = '0;
    any_free  = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      way_match[w] = valid_q[req_idx][w] && (tag_q[w][req_idx] == req_tag);
      if (way_match[w]) hit_way = WAY_W'(w);
      if (!valid_q[req_idx][w]) begin
        free_way = WAY_W'(w);
        any_free = 1'b1;
      end
    end
  end

  // Lookups are only honoured in IDLE, so the FILL cycle still stalls and the
  // held request hits on the following cycle.
  assign hit          = req && (state_q == IDLE) && (|way_match);
  assign miss         = req && (state_q == IDLE) && !(|way_match);
  assign victim_way_d = any_free ? free_way : repl_victim;
  assign vic_dirty    = valid_q[req_idx][victim_way_d] && dirty_q[req_idx][victim_way_d];
  assign hit_line     = line_q[hit_way][req_idx];

  assign p1.stall = req && !hit;
  assign p1.rdata = hit ? hit_line[{req_word, 5'b0} +: 32] : 32'd0;

  assign mem.enable = mem_en_q;
  assign mem.write  = mem_wr_q;
  assign mem.addr   = mem_addr_q;
  assign mem.wdata  = mem_line_q;

  logic              repl_upd, repl_refill;
  logic [IDX_W-1:0]  repl_set;
  logic [WAY_W-1:0]  repl_way;

  assign repl_refill = (state_q == REFILL);
  assign repl_upd    = hit || (repl_refill && mem.ack);
  assign repl_set    = repl_refill ? idx_q : req_idx;
  assign repl_way    = repl_refill ? vic_way_q : hit_way;

  dcache_repl #(
    .SETS  (SETS),
    .WAYS  (WAYS),
    .IDX_W (IDX_W),
    .WAY_W (WAY_W)
  ) u_repl (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .upd_i        (repl_upd),
    .upd_refill_i (repl_refill),
    .upd_set_i    (repl_set),
    .upd_way_i    (repl_way),
    .rd_set_i     (req_idx),
    .victim_o     (repl_victim)
  );

  // Control FSM: state, memory handshake qualifiers, valid/dirty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (hit && req_wr) dirty_q[req_idx][hit_way] <= 1'b1;
          if (miss) begin
            mem_en_q <= 1'b1;
            mem_wr_q <= vic_dirty;
            state_q  <= vic_dirty ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (mem.ack) begin
            dirty_q[idx_q][vic_way_q] <= 1'b0;
            mem_wr_q                  <= 1'b0;
            state_q                   <= REFILL;
          end
        end
        REFILL: begin
          if (mem.ack) begin
            valid_q[idx_q][vic_way_q] <= 1'b1;
            dirty_q[idx_q][vic_way_q] <= 1'b0;
            mem_en_q                  <= 1'b0;
            state_q                   <= FILL;
          end
        end
        FILL:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Datapath: miss context, memory address/line, tag and data arrays.
  always_ff @(posedge clk_i) begin
    if (miss) begin
      vic_way_q  <= victim_way_d;
      idx_q      <= req_idx;
      fill_tag_q <= req_tag;
      mem_line_q <= line_q[victim_way_d][req_idx];
      mem_addr_q <= vic_dirty ? {tag_q[victim_way_d][req_idx], req_idx, {OFF_W{1'b0}}}
                              : {req_tag, req_idx, {OFF_W{1'b0}}};
    end else if (state_q == WRITEBACK && mem.ack) begin
      mem_addr_q <= {fill_tag_q, idx_q, {OFF_W{1'b0}}};
    end
    if (hit && req_wr) begin
      line_q[hit_way][req_idx][{req_word, 5'b0} +: 32] <= p1.wdata;
    end
    if (state_q == REFILL && mem.ack) begin
      line_q[vic_way_q][idx_q] <= mem.rdata;
      tag_q[vic_way_q][idx_q]  <= fill_tag_q;
    end
  end

endmodule

// File: tb/tb_dcache_assoc_top.sv
// Directed scoreboard bench for dcache_assoc_top (SETS=32, WAYS=2, LINE_BYTES=32,
// memory latency 4). Stimulus pushes expected CPU completions and memory
// transactions; independent monitors pop and compare them.
module tb_dcache_assoc_top;

  localparam int LINE_W  = 256;
  localparam int MEM_LAT = 4;

  logic clk;
  logic rst;

  dcache_cpu_if #(.ADDR_W(32))                  p1_bus ();
  dcache_mem_if #(.ADDR_W(32), .LINE_BYTES(32)) mem_bus ();

  dcache_assoc_top #(
    .ADDR_W     (32),
    .LINE_BYTES (32),
    .SETS       (32),
    .WAYS       (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .p1    (p1_bus),
    .mem   (mem_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          stall;
  } cexp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    bit          chk;
    int          widx;
    logic [31:0] wval;
  } mexp_t;

  cexp_t cq[$];
  mexp_t mq[$];
  int checks   = 0;
  int failures = 0;

  logic [LINE_W-1:0] mem_store [logic [31:0]];
  logic [31:0]       start_addr;

  // Default memory contents: word at byte address a reads as C0DE_<a[15:0]>.
  function automatic logic [LINE_W-1:0] line_for(input logic [31:0] a);
    logic [LINE_W-1:0] l;
    logic [31:0]       w;
    if (mem_store.exists(a)) return mem_store[a];
    for (int i = 0; i < 8; i++) begin
      w = a + 32'(4 * i);
      l[i*32 +: 32] = 32'hC0DE0000 | {16'h0, w[15:0]};
    end
    return l;
  endfunction

  task automatic mem_check();
    mexp_t       e;
    logic [31:0] word;
    checks++;
    if (mq.size() == 0) begin
      failures++;
      $display("FAIL mem_unexpected: got wr=%0b addr=%h, required no traffic", mem_bus.write, mem_bus.addr);
      return;
    end
    e = mq.pop_front();
    if (mem_bus.write !== e.wr || mem_bus.addr !== e.addr) begin
      failures++;
      $display("FAIL mem_txn: got wr=%0b addr=%h, required wr=%0b addr=%h", mem_bus.write, mem_bus.addr, e.wr, e.addr);
    end
    if (e.chk) begin
      checks++;
      word = mem_bus.wdata[e.widx*32 +: 32];
      if (word !== e.wval) begin
        failures++;
        $display("FAIL wb_word%0d: got %h, required %h", e.widx, word, e.wval);
      end
    end
    checks++;
    if (mem_bus.addr !== start_addr) begin
      failures++;
      $display("FAIL mem_stable: addr at ack %h, required %h", mem_bus.addr, start_addr);
    end
  endtask

  // Memory model: acknowledges on the MEM_LAT-th cycle of enable.
  initial begin
    int cnt;
    cnt           = 0;
    mem_bus.ack   = 1'b0;
    mem_bus.rdata = '0;
    start_addr    = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_bus.ack = 1'b0;
      if (rst || !mem_bus.enable) begin
        cnt = 0;
      end else begin
        if (cnt == 0) start_addr = mem_bus.addr;
        cnt++;
        if (cnt == MEM_LAT) begin
          cnt         = 0;
          mem_bus.ack = 1'b1;
          mem_check();
          if (mem_bus.write) mem_store[mem_bus.addr] = mem_bus.wdata;
          else               mem_bus.rdata = line_for(mem_bus.addr);
        end
      end
    end
  end

  // CPU monitor: counts stall cycles and checks each completed request.
  initial begin
    int    scnt;
    cexp_t e;
    scnt = 0;
    forever begin
      @(negedge clk);
      if (rst || !(p1_bus.MemRead || p1_bus.MemWrite)) begin
        scnt = 0;
      end else if (p1_bus.stall) begin
        scnt++;
      end else begin
        checks++;
        if (cq.size() == 0) begin
          failures++;
          $display("FAIL cpu_unexpected: completion at addr %h with no expectation", p1_bus.addr);
        end else begin
          e = cq.pop_front();
          if (scnt != e.stall) begin
            failures++;
            $display("FAIL stall_cycles @%h: got %0d, required %0d", p1_bus.addr, scnt, e.stall);
          end
          if (e.rd) begin
            checks++;
            if (p1_bus.rdata !== e.data) begin
              failures++;
              $display("FAIL rdata @%h: got %h, required %h", p1_bus.addr, p1_bus.rdata, e.data);
            end
          end
        end
        scnt = 0;
      end
    end
  end

  task automatic exp_mem(input bit wr, input logic [31:0] addr, input bit chk,
                         input int widx, input logic [31:0] wval);
    mexp_t e;
    e.wr = wr; e.addr = addr; e.chk = chk; e.widx = widx; e.wval = wval;
    mq.push_back(e);
  endtask

  task automatic cpu_op(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_data,
                        input int exp_stall);
    cexp_t e;
    int    n;
    e.rd = rd && !wr; e.data = exp_data; e.stall = exp_stall;
    cq.push_back(e);
    @(posedge clk);
    #1;
    p1_bus.addr     = addr;
    p1_bus.wdata    = wdata;
    p1_bus.MemRead  = rd;
    p1_bus.MemWrite = wr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (p1_bus.stall && n < 200);
    if (p1_bus.stall) begin
      checks++;
      failures++;
      $display("FAIL timeout @%h: still stalled after %0d cycles, required completion", addr, n);
    end
    @(posedge clk);
    #1;
    p1_bus.MemRead  = 1'b0;
    p1_bus.MemWrite = 1'b0;
  endtask

  initial begin
    int n;
    rst             = 1'b1;
    p1_bus.addr     = '0;
    p1_bus.wdata    = '0;
    p1_bus.MemRead  = 1'b0;
    p1_bus.MemWrite = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (mem_bus.enable !== 1'b0) begin failures++; $display("FAIL rst_enable: got %b, required 0", mem_bus.enable); end
    if (mem_bus.write !== 1'b0)  begin failures++; $display("FAIL rst_write: got %b, required 0", mem_bus.write); end
    if (p1_bus.stall !== 1'b0)   begin failures++; $display("FAIL rst_stall: got %b, required 0", p1_bus.stall); end
    if (p1_bus.rdata !== 32'd0)  begin failures++; $display("FAIL rst_rdata: got %h, required 0", p1_bus.rdata); end

    // Clean read miss, then write hit and read-back.
    exp_mem(0, 32'h400, 0, 0, 0);
    cpu_op(1, 0, 32'h400, 0, 32'hC0DE0400, 6);
    cpu_op(0, 1, 32'h404, 32'hDEADBEEF, 0, 0);
    cpu_op(1, 0, 32'h404, 0, 32'hDEADBEEF, 0);
    // Fill the second way, then a dirty eviction of 0x400.
    exp_mem(0, 32'h800, 0, 0, 0);
    cpu_op(1, 0, 32'h800, 0, 32'hC0DE0800, 6);
    exp_mem(1, 32'h400, 1, 1, 32'hDEADBEEF);
    exp_mem(0, 32'hC00, 0, 0, 0);
    cpu_op(1, 0, 32'hC00, 0, 32'hC0DE0C00, 10);
    // Write miss, read-back, read+write both high acts as a write.
    exp_mem(0, 32'h1000, 0, 0, 0);
    cpu_op(0, 1, 32'h1008, 32'h12345678, 0, 6);
    cpu_op(1, 0, 32'h1008, 0, 32'h12345678, 0);
    cpu_op(1, 1, 32'h100C, 32'hA5A5A5A5, 0, 0);
    cpu_op(1, 0, 32'h100C, 0, 32'hA5A5A5A5, 0);
    // Evict clean 0xC00, then dirty 0x1000 carrying the written word.
    exp_mem(0, 32'h1400, 0, 0, 0);
    cpu_op(1, 0, 32'h1400, 0, 32'hC0DE1400, 6);
    exp_mem(1, 32'h1000, 1, 2, 32'h12345678);
    exp_mem(0, 32'h1800, 0, 0, 0);
    cpu_op(1, 0, 32'h1800, 0, 32'hC0DE1800, 10);
    // Set 1: fill A, B; hit A; miss C; then revisit A.
    exp_mem(0, 32'h020, 0, 0, 0);
    cpu_op(1, 0, 32'h020, 0, 32'hC0DE0020, 6);
    exp_mem(0, 32'h420, 0, 0, 0);
    cpu_op(1, 0, 32'h420, 0, 32'hC0DE0420, 6);
    cpu_op(1, 0, 32'h020, 0, 32'hC0DE0020, 0);
    exp_mem(0, 32'h820, 0, 0, 0);
    cpu_op(1, 0, 32'h820, 0, 32'hC0DE0820, 6);
`ifdef DCACHE_PLRU_EN
    cpu_op(1, 0, 32'h020, 0, 32'hC0DE0020, 0);
`else
    exp_mem(0, 32'h020, 0, 0, 0);
    cpu_op(1, 0, 32'h020, 0, 32'hC0DE0020, 6);
`endif

    // Reset in the middle of a refill.
    @(posedge clk);
    #1;
    p1_bus.addr    = 32'h400;
    p1_bus.MemRead = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(mem_bus.enable && !mem_bus.write) && n < 50);
    checks++;
    if (!(mem_bus.enable && !mem_bus.write)) begin
      failures++;
      $display("FAIL refill_start: enable=%b write=%b, required enable=1 write=0", mem_bus.enable, mem_bus.write);
    end
    @(posedge clk);
    #1;
    rst            = 1'b1;
    p1_bus.MemRead = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mem_bus.enable !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_refill: enable=%b, required 0", mem_bus.enable);
    end
    rst = 1'b0;

    // Everything was invalidated: former residents miss again.
    exp_mem(0, 32'h400, 0, 0, 0);
    cpu_op(1, 0, 32'h400, 0, 32'hC0DE0400, 6);
    cpu_op(1, 0, 32'h404, 0, 32'hDEADBEEF, 0);
    exp_mem(0, 32'h1400, 0, 0, 0);
    cpu_op(1, 0, 32'h1400, 0, 32'hC0DE1400, 6);

    repeat (10) @(posedge clk);
    checks += 2;
    if (cq.size() != 0) begin failures++; $display("FAIL cpu_pending: %0d left, required 0", cq.size()); end
    if (mq.size() != 0) begin failures++; $display("FAIL mem_pending: %0d left, required 0", mq.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
